// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state, direction and sprite-set encodings for the sprite animation store.
package sprite_pkg;
    typedef enum logic [1:0] {IDLE, WALK, ATTACK} anim_state_e;
    typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_e;
    localparam logic SET_WALK   = 1'b0;
    localparam logic SET_ATTACK = 1'b1;
endpackage

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: IDLE/WALK/ATTACK sequencer stepped by frame_tick, producing set/dir/frame.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int NUM_DIRS   = 4,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_TICKS = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_tick,
    input  logic [$clog2(NUM_DIRS)-1:0]   dir_in,
    input  logic                          walk,
    input  logic                          attack_req,
    output logic                          set,
    output logic [$clog2(NUM_DIRS)-1:0]   dir,
    output logic [$clog2(NUM_FRAMES)-1:0] frame,
    output logic                          attack_busy
);
    localparam int DW = $clog2(NUM_DIRS);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;

    anim_state_e   state, state_n;
    logic [HW-1:0] hold, hold_n;
    logic [FW-1:0] frame_n;
    logic [DW-1:0] dir_n;
    logic          hold_last, frame_last;

    assign hold_last   = hold == HW'(HOLD_TICKS - 1);
    assign frame_last  = frame == FW'(NUM_FRAMES - 1);
    assign set         = state == ATTACK ? SET_ATTACK : SET_WALK;
    assign attack_busy = state == ATTACK;

    // Attack entry takes priority over a coincident tick, which is then dropped.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        frame_n = frame;
        dir_n   = dir;
        if (attack_req && state != ATTACK) begin
            state_n = ATTACK;
            hold_n  = '0;
            frame_n = '0;
        end else if (frame_tick) begin
            if (state != ATTACK) dir_n = dir_in;
            if ((state == IDLE && walk) || (state == WALK && !walk) ||
                (state == ATTACK && hold_last && frame_last)) begin
                state_n = walk ? WALK : IDLE;
                hold_n  = '0;
                frame_n = '0;
            end else if (state != IDLE) begin
                hold_n  = hold_last ? '0 : hold + 1'b1;
                frame_n = frame + FW'(hold_last);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            hold  <= '0;
            frame <= '0;
            dir   <= '0;
        end else begin
            state <= state_n;
            hold  <= hold_n;
            frame <= frame_n;
            dir   <= dir_n;
        end
    end
endmodule

// File: rtl/sprite_anim_rom.sv
// sprite_anim_rom: single-RAM sprite store for all sets/directions/frames with a 1-cycle pixel port.
module sprite_anim_rom
    import sprite_pkg::*;
#(
    parameter int PIX_BITS        = 3,
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 32,
    parameter int NUM_DIRS        = 4,
    parameter int NUM_FRAMES      = 4,
    parameter int HOLD_TICKS      = 8,
    parameter int TRANSPARENT_IDX = 0,
    parameter     INIT_FILE       = "sprite_anim.mif"
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_tick,
    input  logic [$clog2(NUM_DIRS)-1:0]   dir_in,
    input  logic                          walk,
    input  logic                          attack_req,
    input  logic                          pix_req,
    input  logic [$clog2(SPRITE_W):0]     pix_x,
    input  logic [$clog2(SPRITE_H):0]     pix_y,
    output logic [PIX_BITS-1:0]           q,
    output logic                          q_opaque,
    output logic                          q_valid,
    output logic                          attack_busy,
    output logic [$clog2(NUM_FRAMES)-1:0] cur_frame
);
    localparam int XW    = $clog2(SPRITE_W);
    localparam int YW    = $clog2(SPRITE_H);
    localparam int DW    = $clog2(NUM_DIRS);
    localparam int FW    = $clog2(NUM_FRAMES);
    localparam int AW    = 1 + DW + FW + YW + XW;
    localparam int DEPTH = 2 * NUM_DIRS * NUM_FRAMES * SPRITE_W * SPRITE_H;
    localparam logic [PIX_BITS-1:0] TRANSP = PIX_BITS'(TRANSPARENT_IDX);

    logic          set;
    logic [DW-1:0] dir;
    logic [AW-1:0] addr;
    logic          out_of_range;

    (* ram_init_file = INIT_FILE *) logic [PIX_BITS-1:0] mem [DEPTH];

    sprite_anim_seq #(
        .NUM_DIRS  (NUM_DIRS),
        .NUM_FRAMES(NUM_FRAMES),
        .HOLD_TICKS(HOLD_TICKS)
    ) u_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .dir_in     (dir_in),
        .walk       (walk),
        .attack_req (attack_req),
        .set        (set),
        .dir        (dir),
        .frame      (cur_frame),
        .attack_busy(attack_busy)
    );

    assign addr         = {set, dir, cur_frame, pix_y[YW-1:0], pix_x[XW-1:0]};
    assign out_of_range = pix_x[XW] || pix_y[YW];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q        <= '0;
            q_opaque <= 1'b0;
            q_valid  <= 1'b0;
        end else begin
            q_valid <= pix_req;
            if (pix_req) begin
                q        <= out_of_range ? TRANSP : mem[addr];
                q_opaque <= !out_of_range && mem[addr] != TRANSP;
            end
        end
    end
endmodule

// File: tb/tb_sprite_anim_rom.sv
// tb_sprite_anim_rom: directed scenario tests for the sprite animation store.
module tb_sprite_anim_rom;
    logic       clock = 1'b0;
    logic       reset_n, frame_tick, walk, attack_req, pix_req;
    logic [1:0] dir_in;
    logic [5:0] pix_x, pix_y;
    logic [2:0] q;
    logic       q_opaque, q_valid, attack_busy;
    logic [1:0] cur_frame;
    int         total = 0;
    int         bad = 0;

    always #5 clock = ~clock;

    sprite_anim_rom dut (
        .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .dir_in(dir_in),
        .walk(walk), .attack_req(attack_req), .pix_req(pix_req), .pix_x(pix_x),
        .pix_y(pix_y), .q(q), .q_opaque(q_opaque), .q_valid(q_valid),
        .attack_busy(attack_busy), .cur_frame(cur_frame)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input int x, input int y);
        pix_x   = 6'(x);
        pix_y   = 6'(y);
        pix_req = 1'b1;
        cyc();
        pix_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        if (q !== 3'd0) begin bad++; $display("FAIL reset_q got %0d want 0", q); end
        total++;
        if (q_opaque !== 1'b0) begin bad++; $display("FAIL reset_opaque got %0b want 0", q_opaque); end
        total++;
        if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", q_valid); end
        total++;
        if (attack_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", attack_busy); end
        total++;
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL reset_frame got %0d want 0", cur_frame); end
        total++;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_pixel();
        rd(0, 0);
        if (q !== 3'd3) begin bad++; $display("FAIL pix00_q got %0d want 3", q); end
        total++;
        if (q_valid !== 1'b1) begin bad++; $display("FAIL pix00_valid got %0b want 1", q_valid); end
        total++;
        if (q_opaque !== 1'b1) begin bad++; $display("FAIL pix00_opaque got %0b want 1", q_opaque); end
        total++;
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL pix00_frame got %0d want 0", cur_frame); end
        total++;
        cyc();
        if (q_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got %0b want 0", q_valid); end
        total++;
        if (q !== 3'd3) begin bad++; $display("FAIL hold_q got %0d want 3", q); end
        total++;
    endtask

    task automatic test_range();
        rd(32, 0);
        if (q !== 3'd0) begin bad++; $display("FAIL oorx_q got %0d want 0", q); end
        total++;
        if (q_opaque !== 1'b0) begin bad++; $display("FAIL oorx_opaque got %0b want 0", q_opaque); end
        total++;
        if (q_valid !== 1'b1) begin bad++; $display("FAIL oorx_valid got %0b want 1", q_valid); end
        total++;
        rd(1, 32);
        if (q !== 3'd0) begin bad++; $display("FAIL oory_q got %0d want 0", q); end
        total++;
        if (q_opaque !== 1'b0) begin bad++; $display("FAIL oory_opaque got %0b want 0", q_opaque); end
        total++;
        rd(1, 0);
        if (q !== 3'd7 || q_opaque !== 1'b1) begin bad++; $display("FAIL pix10 got q=%0d op=%0b want q=7 op=1", q, q_opaque); end
        total++;
        rd(2, 1);
        if (q !== 3'd0 || q_opaque !== 1'b0 || q_valid !== 1'b1) begin
            bad++; $display("FAIL transp_pix got q=%0d op=%0b v=%0b want q=0 op=0 v=1", q, q_opaque, q_valid);
        end
        total++;
    endtask

    task automatic test_walk();
        int exp;
        dir_in = 2'd2;
        walk   = 1'b1;
        tick();
        if (cur_frame !== 2'd0 || attack_busy !== 1'b0) begin
            bad++; $display("FAIL walk_entry got f=%0d b=%0b want f=0 b=0", cur_frame, attack_busy);
        end
        total++;
        for (int k = 2; k <= 40; k++) begin
            tick();
            exp = ((k - 1) / 8) % 4;
            if (cur_frame !== 2'(exp)) begin bad++; $display("FAIL walk_k%0d got %0d want %0d", k, cur_frame, exp); end
            total++;
            if (k == 9) begin
                rd(0, 0);
                if (q !== 3'd5) begin bad++; $display("FAIL walk_pix got %0d want 5", q); end
                total++;
            end
        end
        walk = 1'b0;
        tick();
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL walk_stop got %0d want 0", cur_frame); end
        total++;
        ticks(9);
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL idle_hold got %0d want 0", cur_frame); end
        total++;
        walk = 1'b1;
        ticks(8);
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL rewalk_7 got %0d want 0", cur_frame); end
        total++;
        tick();
        if (cur_frame !== 2'd1) begin bad++; $display("FAIL rewalk_8 got %0d want 1", cur_frame); end
        total++;
        ticks(8);
        if (cur_frame !== 2'd2) begin bad++; $display("FAIL rewalk_16 got %0d want 2", cur_frame); end
        total++;
    endtask

    task automatic test_attack();
        attack_req = 1'b1;
        cyc();
        attack_req = 1'b0;
        if (attack_busy !== 1'b1 || cur_frame !== 2'd0) begin
            bad++; $display("FAIL atk_entry got b=%0b f=%0d want b=1 f=0", attack_busy, cur_frame);
        end
        total++;
        dir_in = 2'd3;
        tick();
        rd(0, 0);
        if (q !== 3'd6) begin bad++; $display("FAIL atk_dir_frozen got %0d want 6", q); end
        total++;
        ticks(7);
        if (cur_frame !== 2'd1) begin bad++; $display("FAIL atk_8 got %0d want 1", cur_frame); end
        total++;
        ticks(23);
        if (attack_busy !== 1'b1 || cur_frame !== 2'd3) begin
            bad++; $display("FAIL atk_31 got b=%0b f=%0d want b=1 f=3", attack_busy, cur_frame);
        end
        total++;
        tick();
        if (attack_busy !== 1'b0 || cur_frame !== 2'd0) begin
            bad++; $display("FAIL atk_exit got b=%0b f=%0d want b=0 f=0", attack_busy, cur_frame);
        end
        total++;
        ticks(8);
        if (cur_frame !== 2'd1) begin bad++; $display("FAIL post_atk_walk got %0d want 1", cur_frame); end
        total++;
        rd(0, 0);
        if (q !== 3'd4) begin bad++; $display("FAIL post_atk_dir got %0d want 4", q); end
        total++;
    endtask

    task automatic test_collision();
        walk = 1'b0;
        tick();
        if (attack_busy !== 1'b0 || cur_frame !== 2'd0) begin
            bad++; $display("FAIL col_idle got b=%0b f=%0d want b=0 f=0", attack_busy, cur_frame);
        end
        total++;
        attack_req = 1'b1;
        frame_tick = 1'b1;
        cyc();
        attack_req = 1'b0;
        frame_tick = 1'b0;
        if (attack_busy !== 1'b1 || cur_frame !== 2'd0) begin
            bad++; $display("FAIL col_entry got b=%0b f=%0d want b=1 f=0", attack_busy, cur_frame);
        end
        total++;
        ticks(7);
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL col_tick_dropped got %0d want 0", cur_frame); end
        total++;
        tick();
        if (cur_frame !== 2'd1) begin bad++; $display("FAIL col_8 got %0d want 1", cur_frame); end
        total++;
        attack_req = 1'b1;
        cyc();
        attack_req = 1'b0;
        cyc();
        if (attack_busy !== 1'b1 || cur_frame !== 2'd1) begin
            bad++; $display("FAIL col_second_req got b=%0b f=%0d want b=1 f=1", attack_busy, cur_frame);
        end
        total++;
        rd(0, 0);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        if (attack_busy !== 1'b0 || cur_frame !== 2'd0 || q_valid !== 1'b0 || q !== 3'd0) begin
            bad++; $display("FAIL async_reset got b=%0b f=%0d v=%0b q=%0d want all 0", attack_busy, cur_frame, q_valid, q);
        end
        total++;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        walk       = 1'b0;
        attack_req = 1'b0;
        pix_req    = 1'b0;
        dir_in     = 2'd0;
        pix_x      = '0;
        pix_y      = '0;
        dut.mem[0]     = 3'd3;
        dut.mem[1]     = 3'd7;
        dut.mem[34]    = 3'd0;
        dut.mem[9216]  = 3'd5;
        dut.mem[13312] = 3'd4;
        dut.mem[24576] = 3'd6;
        dut.mem[28672] = 3'd7;
        test_reset();
        test_pixel();
        test_range();
        test_walk();
        test_attack();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_anim_rom.md
# sprite_anim_rom

Parametrised sprite store plus animation sequencer that replaces the one-ROM-per-frame sprite modules: a single block RAM holds every frame of every direction for a walk set and an attack set. An internal state machine, advanced by the per-video-frame tick, selects the frame. The pixel port returns a palette index one clock after the request, with a transparency flag. The block sits between the player-movement logic and the color mapper.

## Interface
- PIX_BITS, 3, palette index width
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- NUM_DIRS, 4, directions; encoding 0=down, 1=up, 2=left, 3=right
- NUM_FRAMES, 4, frames per direction per set (power of two)
- HOLD_TICKS, 8, frame_ticks each frame is displayed
- TRANSPARENT_IDX, 0, palette index treated as transparent
- INIT_FILE, "sprite_anim.mif", ram_init_file for the memory
- clock  in  1  system clock, all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- dir_in  in  $clog2(NUM_DIRS)  requested facing direction
- walk  in  1  level; high while the player moves
- attack_req  in  1  one-cycle pulse to start the attack animation
- pix_req  in  1  pixel read request
- pix_x  in  $clog2(SPRITE_W)+1  sprite-local x, extra bit flags out-of-range
- pix_y  in  $clog2(SPRITE_H)+1  sprite-local y, extra bit flags out-of-range
- q  out  PIX_BITS  palette index
- q_opaque  out  1  high when q != TRANSPARENT_IDX and the request was in range
- q_valid  out  1  q/q_opaque correspond to the request of the previous cycle
- attack_busy  out  1  high while in ATTACK
- cur_frame  out  $clog2(NUM_FRAMES)  displayed frame number

## Operation
- Memory depth = 2*NUM_DIRS*NUM_FRAMES*SPRITE_W*SPRITE_H (default 32768 x 3). Address = {set, dir, frame, y, x}, with set 0=walk and set 1=attack.
- State machine IDLE / WALK / ATTACK. A hold counter counts frame_ticks from 0 to HOLD_TICKS-1.
- IDLE: frame 0, set 0. On frame_tick with walk=1, go to WALK with frame 0 and hold 0.
- WALK: on frame_tick, if walk=0, go to IDLE. Otherwise increment hold; when hold hits HOLD_TICKS-1, clear it and advance frame, wrapping NUM_FRAMES-1 to 0.
- ATTACK: set 1. Entered the cycle after attack_req from IDLE or WALK, with frame and hold reset to 0. Frames advance as in WALK.
- ATTACK exit: when the last frame's hold expires, return on that tick to WALK if walk=1, else IDLE, with frame 0.
- attack_req during ATTACK is ignored. attack_req and frame_tick in the same cycle: ATTACK entry wins and the tick is not counted.
- Direction register loads dir_in on frame_tick in IDLE/WALK only. It is frozen in ATTACK, so no mid-frame tearing or mid-swing turning.
- Pixel path: on pix_req, the address is formed from the current state registers and pix_x/pix_y, then read synchronously. If the MSB of pix_x or pix_y is set, the response is q=TRANSPARENT_IDX, q_opaque=0.

## Timing
- Read latency is exactly 1 cycle: pix_req at edge N gives q_valid=1 after edge N+1. Back-to-back requests are supported at full rate.
- q holds its last value while q_valid=0.
- State, frame and dir change only on the edge that samples frame_tick or attack_req. A request in the same cycle uses the pre-update values.
- Reset values:
  - q=0, q_opaque=0, q_valid=0
  - attack_busy=0, cur_frame=0
  - state IDLE, dir 0, hold 0
- Reset asserted mid-ATTACK returns to IDLE immediately and asynchronously.
- Widths: counters are exactly $clog2 of their range. The frame wrap relies on power-of-two NUM_FRAMES. HOLD_TICKS=1 advances one frame per tick.

## Structure
- Shared package sprite_pkg:
  - anim_state_e (IDLE, WALK, ATTACK)
  - dir_e constants (DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT)
  - SET_WALK/SET_ATTACK constants
- Sub-module sprite_anim_seq holds the state machine, hold/frame counters and the direction register. It outputs {set, dir, frame} to the top.
- The top holds the address concatenation, the inferred synchronous RAM carrying the ram_init_file attribute, and the range/transparency pipeline flag.

## Test plan
- Reset, then pix_req at (0,0) with a MIF whose word 0 = 3: next cycle q=3, q_valid=1, q_opaque=1, cur_frame=0.
- walk=1 for 40 frame_ticks with HOLD_TICKS=8: cur_frame steps 0→1→2→3→0 every 8 ticks. walk=0 on the next tick gives IDLE with cur_frame=0.
- attack_req during WALK at frame 2: attack_busy=1 next cycle and cur_frame=0. dir_in changes are ignored. After 32 ticks attack_busy=0 and state is WALK.
- pix_x=32 (out of range): q=TRANSPARENT_IDX, q_opaque=0, q_valid=1. A MIF pixel equal to TRANSPARENT_IDX also gives q_opaque=0.
- attack_req and frame_tick in the same cycle, then a second attack_req mid-attack: one attack occurs, the tick is not counted and the second request is ignored. reset_n pulsed mid-attack clears attack_busy without waiting for a clock edge.
